// File: rtl/alu_regfile.sv
// alu_regfile: operand-supply and write-back stage for the 16-bit ALU.
// Sixteen general-purpose registers feed registered operands A and B; the
// write port takes the ALU result S, and a 5-bit PSR {C,L,F,Z,N} captures the
// ALU flags under a per-bit mask.
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a same-cycle write
// to the address being read is forwarded straight into a_out/b_out.
module alu_regfile #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned FLAG_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_en,
    input  logic [FLAG_W-1:0] flag_mask,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [FLAG_W-1:0] flags_out
);

    // NUM_REGS equals 2**ADDR_W, so every address maps to a real register
    // and no wrap or clamp logic is needed on any port.
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic [FLAG_W-1:0] flags_next;

    // Register array write port; reset clears every entry and cancels any write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Operand selection: stale array value, or forwarded write data when bypass is built in.
    always_comb begin
        a_next = regs[ra_addr];
        b_next = regs[rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == ra_addr)) begin
            a_next = wr_data;
        end
        if (wr_en && (wr_addr == rb_addr)) begin
            b_next = wr_data;
        end
`endif
    end

    // Registered read ports; stall freezes both operands while writes continue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
        end else if (!stall) begin
            a_out <= a_next;
            b_out <= b_next;
        end
    end

    // Masked PSR merge: masked bits take the new flag, the rest keep their value.
    always_comb begin
        flags_next = (flags_out & ~flag_mask) | (flags_in & flag_mask);
    end

    // PSR register, independent of wr_en and stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_out <= '0;
        end else if (flag_en) begin
            flags_out <= flags_next;
        end
    end

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Operand-supply and write-back stage for the 16-bit ALU.
- Holds 16 general-purpose 16-bit registers and a 5-bit processor status register (PSR).
- Registered read ports drive ALU inputs A and B one cycle after the address is presented.
- The write port takes the ALU result S; the PSR captures the ALU CLFZN flags under per-bit mask.

Parameters:
DATA_W, 16, register and port data width
ADDR_W, 4, register address width
NUM_REGS, 16, number of registers (must equal 2**ADDR_W)
FLAG_W, 5, PSR width, bit order {C,L,F,Z,N} with C at MSB

Ports:
clk  input  1  single system clock, all state changes on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
stall  input  1  1 = hold a_out/b_out registers (writes still occur)
ra_addr  input  ADDR_W  read address for operand A
rb_addr  input  ADDR_W  read address for operand B
a_out  output  DATA_W  registered operand A, to ALU A
b_out  output  DATA_W  registered operand B, to ALU B
wr_en  input  1  write-back enable
wr_addr  input  ADDR_W  write-back destination register
wr_data  input  DATA_W  write-back data, from ALU S
flag_en  input  1  PSR update enable
flag_mask  input  FLAG_W  per-bit PSR update mask, 1 = update that bit
flags_in  input  FLAG_W  new flag values, from ALU CLFZN
flags_out  output  FLAG_W  current PSR contents

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all registers, a_out, b_out and flags_out become 0 on that edge;
  - wr_en and flag_en are ignored during that cycle;
  - reset in the middle of a write cancels the write, and the register reads 0 afterwards.
- Read latency is 1 cycle:
  - with stall=0, a_out <= reg[ra_addr] and b_out <= reg[rb_addr] at each edge;
  - with stall=1, a_out and b_out hold their previous values;
  - addresses are sampled at the edge, and there is no combinational path from the addresses to the outputs.
- Write:
  - when wr_en=1, reg[wr_addr] <= wr_data at the edge;
  - writes are accepted regardless of stall;
  - wr_en=0 leaves all registers unchanged.
- Same-cycle read and write to the same address: the result depends on REGFILE_BYPASS_EN (see Optional Feature).
- ra_addr==rb_addr is legal; both outputs carry the same value.
- PSR:
  - when flag_en=1, for each bit i: flags_out[i] <= flag_mask[i] ? flags_in[i] : flags_out[i];
  - when flag_en=0, the PSR holds;
  - PSR updates are independent of wr_en and stall;
  - the new PSR value is visible on flags_out the cycle after the edge.
- Write and flag update can occur in the same cycle; both take effect on that edge.
- No register is hardwired; R0 is writable like every other register.
- Out-of-range addresses do not exist, since NUM_REGS == 2**ADDR_W; the implementation must not add wrap or clamp logic.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - when stall=0, wr_en=1 and wr_addr==ra_addr at an edge, a_out <= wr_data instead of the stale register value;
  - b_out follows the same rule with rb_addr;
  - this gives a back-to-back dependent ALU op without a bubble.
- Undefined:
  - a_out/b_out take the pre-write register contents;
  - the new value is visible on the next read;
  - the controller must insert one bubble.
- The write to the register array is identical in both builds.

Test Plan:
1. Reset then read-back: hold rst_n=0 for 2 cycles, release, read R0..R15 -> every a_out/b_out value is 0x0000 and flags_out is 5'b00000.
2. Write/read latency: write R3=0xBEEF, next cycle set ra_addr=3 and rb_addr=3 -> a_out=b_out=0xBEEF one cycle after the address is presented; R2 still reads 0x0000.
3. Same-cycle hazard: R5=0x1111, then in one cycle wr_en=1, wr_addr=5, wr_data=0x2222 with ra_addr=5 -> a_out=0x2222 with REGFILE_BYPASS_EN, 0x1111 without; either build reads 0x2222 on the following cycle.
4. Masked flags: PSR=5'b00000, then flag_en=1, flag_mask=5'b10011, flags_in=5'b11111 -> flags_out=5'b10011; next flag_en=0 with flags_in=0 -> PSR holds 5'b10011.
5. Stall hold: a_out=0x00AA from R1; assert stall=1, change ra_addr to 7 and write R7=0x7777 -> a_out stays 0x00AA; drop stall -> a_out=0x7777 next cycle.
6. Reset mid-operation: in the same cycle assert rst_n=0, wr_en=1, wr_addr=9, wr_data=0xFFFF, flag_en=1, flag_mask=5'b11111, flags_in=5'b11111 -> after release R9 reads 0x0000 and flags_out=5'b00000.
